// File: rtl/lshift2_pipe_if.sv
// Valid/ready bundle for the x4 shifter: operand in on the producer side, widened result out on the consumer side.
interface lshift2_pipe_if #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 2
);
  logic [WIDTH-1:0]       entrada;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH+SHIFT-1:0] saida;
  logic                   out_valid;
  logic                   out_ready;

  // master is the environment (producer plus consumer), slave is the shifter itself
  modport master (
    output entrada, in_valid, out_ready,
    input  in_ready, saida, out_valid
  );

  modport slave (
    input  entrada, in_valid, out_ready,
    output in_ready, saida, out_valid
  );
endinterface

// File: rtl/lshift2_pipe.sv
// Registered logical left shift by SHIFT with zero fill, widened so no bits are lost,
// behind a single valid/ready pipeline stage.
module lshift2_pipe #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 2
) (
  input  logic          clk,
  input  logic          reset,
  lshift2_pipe_if.slave bus
);

  logic [WIDTH+SHIFT-1:0] saida_q;
  logic                   out_valid_q;
  logic                   accept;

  // The stage can take a new operand when empty or when its current result leaves this edge
  assign bus.in_ready  = ~out_valid_q | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.saida     = saida_q;
  assign bus.out_valid = out_valid_q;

  // saida only loads on an accepted operand, so an X on entrada while idle never reaches it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saida_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      saida_q     <= {bus.entrada, {SHIFT{1'b0}}};
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lshift2_pipe.sv
// Scoreboard bench for lshift2_pipe: accepted operands queue their expected result,
// a monitor pops and compares on every output transfer.
module tb_lshift2_pipe;

  logic clk;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  logic [17:0] exp_q[$];

  lshift2_pipe_if #(.WIDTH(16), .SHIFT(2)) bus ();

  lshift2_pipe #(.WIDTH(16), .SHIFT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive just after the active edge; decide acceptance mid-cycle when in_ready has settled
  task automatic applyStimulus(input logic [15:0] d, input logic v, input logic r);
    @(posedge clk);
    #1;
    bus.entrada   = d;
    bus.in_valid  = v;
    bus.out_ready = r;
    @(negedge clk);
    if (v && bus.in_ready) exp_q.push_back({d, 2'b00});
  endtask

  // Every output transfer must match the oldest accepted operand
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL scoreboard_unexpected: got %h, expected no output", bus.saida);
        end else begin
          checkOutput("scoreboard", bus.saida, exp_q.pop_front());
        end
      end
    end
  end

  logic [15:0] vec_in  [5] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'hA5A5};
  logic [17:0] vec_out [5] = '{18'h00004, 18'h3FFFC, 18'h20000, 18'h00000, 18'h29694};

  initial begin
    reset         = 1'b0;
    bus.entrada   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_saida", bus.saida, 18'h0);
    checkOutput("reset_out_valid", {17'h0, bus.out_valid}, 18'h0);
    reset = 1'b1;
    #1;
    checkOutput("reset_in_ready", {17'h0, bus.in_ready}, 18'h1);

    // directed vectors, one per cycle, each visible exactly one cycle after acceptance
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vec_in[i], 1'b1, 1'b1);
      if (i > 0) checkOutput("directed_latency", bus.saida, vec_out[i-1]);
    end
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("directed_last", bus.saida, vec_out[4]);
    applyStimulus(16'h0000, 1'b0, 1'b1);

    // back-to-back streaming
    applyStimulus(16'h1234, 1'b1, 1'b1);
    applyStimulus(16'h00FF, 1'b1, 1'b1);
    checkOutput("b2b_first", bus.saida, 18'h048D0);
    checkOutput("b2b_valid1", {17'h0, bus.out_valid}, 18'h1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("b2b_second", bus.saida, 18'h003FC);
    checkOutput("b2b_valid2", {17'h0, bus.out_valid}, 18'h1);
    applyStimulus(16'h0000, 1'b0, 1'b1);

    // backpressure: held result, operand 0x0003 waits for the stall to clear
    applyStimulus(16'h4000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0003, 1'b1, 1'b0);
      checkOutput("stall_saida", bus.saida, 18'h10000);
      checkOutput("stall_in_ready", {17'h0, bus.in_ready}, 18'h0);
      checkOutput("stall_out_valid", {17'h0, bus.out_valid}, 18'h1);
    end
    applyStimulus(16'h0003, 1'b1, 1'b1);
    checkOutput("release_in_ready", {17'h0, bus.in_ready}, 18'h1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("release_saida", bus.saida, 18'h0000C);
    applyStimulus(16'h0000, 1'b0, 1'b1);

    // idle drain, then X on entrada while idle must not disturb saida
    applyStimulus(16'h7FFF, 1'b1, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("drain_saida", bus.saida, 18'h1FFFC);
    checkOutput("drain_valid", {17'h0, bus.out_valid}, 18'h1);
    applyStimulus(16'hxxxx, 1'b0, 1'b1);
    checkOutput("drain_idle_valid", {17'h0, bus.out_valid}, 18'h0);
    checkOutput("drain_hold_saida", bus.saida, 18'h1FFFC);
    applyStimulus(16'hxxxx, 1'b0, 1'b1);
    checkOutput("xsafe_saida", bus.saida, 18'h1FFFC);

    // asynchronous reset while a result is held
    applyStimulus(16'hFFFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    checkOutput("prereset_saida", bus.saida, 18'h3FFFC);
    checkOutput("prereset_valid", {17'h0, bus.out_valid}, 18'h1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_reset_saida", bus.saida, 18'h0);
    checkOutput("async_reset_valid", {17'h0, bus.out_valid}, 18'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("postreset_in_ready", {17'h0, bus.in_ready}, 18'h1);

    // random operands with random valid/ready
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("scoreboard_empty", 18'(exp_q.size()), 18'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
